grid_arbiter: RTL and testbench

Shares the single map-grid lookup port (cell coordinate in, 3-bit cell type out) between two requesters: port A, the player movement/collision updater, and port B, the ray caster. Requests are arbitrated, addresses are registered onto the grid memory, and each result comes back after the memory's fixed read latency with a one-cycle valid pulse to the winner. Out-of-map coordinates resolve to a solid wall, so neither client needs its own bounds check.

---
 rtl/grid_arbiter_if.sv | 30 +++
 rtl/grid_arbiter.sv | 145 ++++++++++++++
 tb/tb_grid_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/grid_arbiter_if.sv
// Bundle of the two requester ports, the grid memory port and busy for grid_arbiter.
// The arbiter takes the slave view; requesters plus the grid memory take the master view.
interface grid_arbiter_if;
  logic       a_req;
  logic [5:0] a_x;
  logic [4:0] a_y;
  logic       a_valid;
  logic [2:0] a_data;

  logic       b_req;
  logic [5:0] b_x;
  logic [4:0] b_y;
  logic       b_valid;
  logic [2:0] b_data;

  logic [5:0] mem_x;
  logic [4:0] mem_y;
  logic [2:0] mem_out;
  logic       busy;

  modport slave (
    input  a_req, a_x, a_y, b_req, b_x, b_y, mem_out,
    output a_valid, a_data, b_valid, b_data, mem_x, mem_y, busy
  );

  modport master (
    output a_req, a_x, a_y, b_req, b_x, b_y, mem_out,
    input  a_valid, a_data, b_valid, b_data, mem_x, mem_y, busy
  );
endinterface

// File: rtl/grid_arbiter.sv
// Two-port arbiter for the map-grid lookup port; out-of-map cells read as solid wall (3'b111).
// Define GRID_ARB_FIXED_PRI_EN for fixed A-over-B priority; default is round-robin.
module grid_arbiter #(
  parameter int GRID_W = 40,
  parameter int GRID_H = 30,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  grid_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  localparam logic [2:0] LAT_C    = 3'(RD_LAT);
  localparam logic [6:0] GRID_W_C = 7'(GRID_W);
  localparam logic [5:0] GRID_H_C = 6'(GRID_H);
  localparam logic [2:0] WALL     = 3'b111;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic [5:0] mem_x_q, mem_x_d;
  logic [4:0] mem_y_q, mem_y_d;
  logic       oob_q, oob_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] data_q, data_d;
  logic       a_valid_q, a_valid_d;
  logic       b_valid_q, b_valid_d;
  logic       busy_q, busy_d;

  logic       grant_a, grant_b;
  logic [5:0] sel_x;
  logic [4:0] sel_y;

`ifdef GRID_ARB_FIXED_PRI_EN
  assign grant_a = bus.a_req;
`else
  logic       last_q, last_d;

  // On a tie, the port that was not granted last time wins.
  assign grant_a = bus.a_req && (!bus.b_req || (last_q == OWN_B));
`endif
  assign grant_b = bus.b_req && !grant_a;

  assign sel_x = grant_a ? bus.a_x : bus.b_x;
  assign sel_y = grant_a ? bus.a_y : bus.b_y;

  always_comb begin
    // NOTE: every _d starts from its _q (valids from 0), so no path leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    owner_d   = owner_q;
    mem_x_d   = mem_x_q;
    mem_y_d   = mem_y_q;
    oob_d     = oob_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    a_valid_d = 1'b0;
    b_valid_d = 1'b0;
`ifndef GRID_ARB_FIXED_PRI_EN
    last_d    = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant_a || grant_b) begin
          owner_d = grant_a ? OWN_A : OWN_B;
          mem_x_d = sel_x;
          mem_y_d = sel_y;
          oob_d   = ({1'b0, sel_x} >= GRID_W_C) || ({1'b0, sel_y} >= GRID_H_C);
          cnt_d   = LAT_C;
          state_d = ST_WAIT;
`ifndef GRID_ARB_FIXED_PRI_EN
          last_d  = grant_a ? OWN_A : OWN_B;
`endif
        end
      end

      ST_WAIT: begin
        if (cnt_q == 3'd1) begin
          // Out-of-map lookups ignore the memory and report a wall.
          data_d    = oob_q ? WALL : bus.mem_out;
          a_valid_d = (owner_q == OWN_A);
          b_valid_d = (owner_q == OWN_B);
          cnt_d     = 3'd0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_A;
      mem_x_q   <= '0;
      mem_y_q   <= '0;
      oob_q     <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      busy_q    <= 1'b0;
`ifndef GRID_ARB_FIXED_PRI_EN
      last_q    <= OWN_B;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      mem_x_q   <= mem_x_d;
      mem_y_q   <= mem_y_d;
      oob_q     <= oob_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      busy_q    <= busy_d;
`ifndef GRID_ARB_FIXED_PRI_EN
      last_q    <= last_d;
`endif
    end
  end

  assign bus.mem_x   = mem_x_q;
  assign bus.mem_y   = mem_y_q;
  assign bus.a_valid = a_valid_q;
  assign bus.b_valid = b_valid_q;
  assign bus.a_data  = data_q;
  assign bus.b_data  = data_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_grid_arbiter.sv
// Directed bench for grid_arbiter: cycle-by-cycle vector table on an RD_LAT=1 instance,
// then hand sequences on an RD_LAT=3 instance for capture timing and mid-transaction reset.
module tb_grid_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic rst3_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  grid_arbiter_if bus1 ();
  grid_arbiter_if bus3 ();

  grid_arbiter #(.GRID_W(40), .GRID_H(30), .RD_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  grid_arbiter #(.GRID_W(40), .GRID_H(30), .RD_LAT(3)) dut3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .bus   (bus3.slave)
  );

  // Grid memory model for the RD_LAT=1 instance: cell(x,y) = (x + y + 5) mod 8.
  logic [7:0] cell_sum;
  always_comb begin
    cell_sum      = 8'(bus1.mem_x) + 8'(bus1.mem_y) + 8'd5;
    bus1.mem_out  = cell_sum[2:0];
  end

  typedef struct {
    logic       a_req;
    logic [5:0] a_x;
    logic [4:0] a_y;
    logic       b_req;
    logic [5:0] b_x;
    logic [4:0] b_y;
    logic       exp_av;
    logic       exp_bv;
    logic [2:0] exp_data;
    logic       exp_busy;
    logic [5:0] exp_mx;
    logic [4:0] exp_my;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int ar, int ax, int ay, int br, int bx, int by,
                              int av, int bv, int d, int bs, int mx, int my);
    vec_t v;
    v.a_req    = 1'(ar);
    v.a_x      = 6'(ax);
    v.a_y      = 5'(ay);
    v.b_req    = 1'(br);
    v.b_x      = 6'(bx);
    v.b_y      = 5'(by);
    v.exp_av   = 1'(av);
    v.exp_bv   = 1'(bv);
    v.exp_data = 3'(d);
    v.exp_busy = 1'(bs);
    v.exp_mx   = 6'(mx);
    v.exp_my   = 5'(my);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    int   cycles;

    // Each row: inputs applied before an edge, outputs expected after it (RD_LAT=1).
    vecs.push_back(mk(1, 3, 2, 0, 0, 0,   0, 0, 0, 1,  3,  2)); // grant A
    vecs.push_back(mk(1, 3, 2, 0, 0, 0,   1, 0, 2, 1,  3,  2)); // A valid, cell(3,2)=2
    vecs.push_back(mk(1, 3, 2, 0, 0, 0,   0, 0, 2, 0,  3,  2)); // back to IDLE
`ifdef GRID_ARB_FIXED_PRI_EN
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   0, 0, 2, 1,  5,  1)); // tie -> A
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   1, 0, 3, 1,  5,  1));
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   0, 0, 3, 0,  5,  1));
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   0, 0, 3, 1,  5,  1)); // tie -> A again
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   1, 0, 3, 1,  5,  1));
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   0, 0, 3, 0,  5,  1));
    vecs.push_back(mk(0, 0, 0, 1, 7, 5,   0, 0, 3, 1,  7,  5)); // A dropped -> B
    vecs.push_back(mk(0, 0, 0, 1, 7, 5,   0, 1, 1, 1,  7,  5));
    vecs.push_back(mk(0, 0, 0, 1, 7, 5,   0, 0, 1, 0,  7,  5));
`else
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   0, 0, 2, 1,  7,  5)); // tie, last=A -> B
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   0, 1, 1, 1,  7,  5)); // cell(7,5)=1
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   0, 0, 1, 0,  7,  5));
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   0, 0, 1, 1,  5,  1)); // tie, last=B -> A
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   1, 0, 3, 1,  5,  1)); // cell(5,1)=3
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   0, 0, 3, 0,  5,  1));
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   0, 0, 3, 1,  7,  5)); // tie -> B
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   0, 1, 1, 1,  7,  5));
    vecs.push_back(mk(1, 5, 1, 1, 7, 5,   0, 0, 1, 0,  7,  5));
`endif
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 1, 0,  7,  5)); // no request: hold
    vecs.push_back(mk(0, 0, 0, 1, 40, 5,  0, 0, 1, 1, 40,  5)); // x = GRID_W
    vecs.push_back(mk(0, 0, 0, 1, 40, 5,  0, 1, 7, 1, 40,  5)); // wall
    vecs.push_back(mk(0, 0, 0, 1, 40, 5,  0, 0, 7, 0, 40,  5));
    vecs.push_back(mk(0, 0, 0, 1, 39, 29, 0, 0, 7, 1, 39, 29)); // last legal cell
    vecs.push_back(mk(0, 0, 0, 1, 39, 29, 0, 1, 1, 1, 39, 29)); // cell(39,29)=1
    vecs.push_back(mk(0, 0, 0, 1, 39, 29, 0, 0, 1, 0, 39, 29));
    vecs.push_back(mk(0, 0, 0, 1, 10, 31, 0, 0, 1, 1, 10, 31)); // y beyond GRID_H
    vecs.push_back(mk(0, 0, 0, 1, 10, 31, 0, 1, 7, 1, 10, 31)); // wall, same latency
    vecs.push_back(mk(0, 0, 0, 1, 10, 31, 0, 0, 7, 0, 10, 31));

    rst_n  = 1'b0;
    rst3_n = 1'b0;
    bus1.a_req = 1'b0; bus1.a_x = '0; bus1.a_y = '0;
    bus1.b_req = 1'b0; bus1.b_x = '0; bus1.b_y = '0;
    bus3.a_req = 1'b0; bus3.a_x = '0; bus3.a_y = '0;
    bus3.b_req = 1'b0; bus3.b_x = '0; bus3.b_y = '0;
    bus3.mem_out = 3'd0;

    repeat (2) @(negedge clk);
    check("rst_busy",    32'(bus1.busy),    32'd0);
    check("rst_mem_x",   32'(bus1.mem_x),   32'd0);
    check("rst_mem_y",   32'(bus1.mem_y),   32'd0);
    check("rst_a_data",  32'(bus1.a_data),  32'd0);
    check("rst_a_valid", 32'(bus1.a_valid), 32'd0);
    check("rst_b_valid", 32'(bus1.b_valid), 32'd0);
    check("rst3_busy",   32'(bus3.busy),    32'd0);
    rst_n  = 1'b1;
    rst3_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus1.a_req = vecs[i].a_req; bus1.a_x = vecs[i].a_x; bus1.a_y = vecs[i].a_y;
      bus1.b_req = vecs[i].b_req; bus1.b_x = vecs[i].b_x; bus1.b_y = vecs[i].b_y;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_a_valid", i), 32'(bus1.a_valid), 32'(vecs[i].exp_av));
      check($sformatf("v%0d_b_valid", i), 32'(bus1.b_valid), 32'(vecs[i].exp_bv));
      check($sformatf("v%0d_a_data",  i), 32'(bus1.a_data),  32'(vecs[i].exp_data));
      check($sformatf("v%0d_b_data",  i), 32'(bus1.b_data),  32'(vecs[i].exp_data));
      check($sformatf("v%0d_busy",    i), 32'(bus1.busy),    32'(vecs[i].exp_busy));
      check($sformatf("v%0d_mem_xy",  i), {21'd0, bus1.mem_x, bus1.mem_y},
            {21'd0, vecs[i].exp_mx, vecs[i].exp_my});
    end
    bus1.a_req = 1'b0;
    bus1.b_req = 1'b0;

    // RD_LAT=3: mem_out changes every cycle; the value present at E0+3 must be captured.
    bus3.a_req = 1'b1; bus3.a_x = 6'd2; bus3.a_y = 5'd3; bus3.mem_out = 3'd4;
    @(negedge clk);                                          // after E0
    check("l3_e0_busy",   32'(bus3.busy),    32'd1);
    check("l3_e0_mem_x",  32'(bus3.mem_x),   32'd2);
    check("l3_e0_valid",  32'(bus3.a_valid), 32'd0);
    bus3.mem_out = 3'd1;
    @(negedge clk);                                          // after E0+1
    check("l3_e1_valid",  32'(bus3.a_valid), 32'd0);
    bus3.mem_out = 3'd2;
    @(negedge clk);                                          // after E0+2
    check("l3_e2_valid",  32'(bus3.a_valid), 32'd0);
    bus3.mem_out = 3'd5;
    @(negedge clk);                                          // after E0+3
    check("l3_e3_valid",  32'(bus3.a_valid), 32'd1);
    check("l3_e3_bvalid", 32'(bus3.b_valid), 32'd0);
    check("l3_e3_data",   32'(bus3.a_data),  32'd5);
    bus3.mem_out = 3'd6;
    @(negedge clk);                                          // after E0+4
    check("l3_e4_valid",  32'(bus3.a_valid), 32'd0);
    check("l3_e4_busy",   32'(bus3.busy),    32'd0);
    check("l3_e4_data",   32'(bus3.a_data),  32'd5);
    bus3.a_req = 1'b0;

    // Reset during WAIT: abort with no pulse, then a held request is served afresh.
    @(negedge clk);
    bus3.a_req = 1'b1; bus3.a_x = 6'd1; bus3.a_y = 5'd1; bus3.mem_out = 3'd3;
    @(negedge clk);
    check("abort_busy_pre", 32'(bus3.busy), 32'd1);
    rst3_n = 1'b0;
    #1;
    check("abort_busy_async", 32'(bus3.busy), 32'd0);
    got = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus3.a_valid) got = 1'b1;
    end
    check("abort_no_valid", 32'(got), 32'd0);
    bus3.mem_out = 3'd6;
    rst3_n = 1'b1;
    got    = 1'b0;
    cycles = -1;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (bus3.a_valid) begin
        got    = 1'b1;
        cycles = c;
      end
    end
    check("regrant_got_valid", 32'(got), 32'd1);
    check("regrant_latency",   32'(cycles), 32'd3);
    check("regrant_data",      32'(bus3.a_data), 32'd6);
    bus3.a_req = 1'b0;
    @(negedge clk);
    check("regrant_idle", 32'(bus3.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
